// File: rtl/vector_execute_unit.sv
// VEC_SIZE-lane vector execute stage: ALU ops, multi-cycle shift-add MUL, N/Z flags, branch resolution.
// Optional: define VEXEC_SATURATE_EN for signed saturating ADD/SUB.
module vector_execute_unit #(
  parameter int REG_SIZE = 16,
  parameter int VEC_SIZE = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2:0]                         ExecuteOp,
  input  logic                               overwriteFlags,
  input  logic [2:0]                         pcWrEn,
  input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vect1,
  input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vect2,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  vectOut,
  output logic                               pcWrEnOut,
  output logic [1:0]                         flags
);

  localparam int SHW = $clog2(REG_SIZE);
  localparam int MSB = REG_SIZE - 1;
  localparam logic [SHW-1:0] CNT_INIT = SHW'(REG_SIZE - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

`ifdef VEXEC_SATURATE_EN
  localparam logic [REG_SIZE-1:0] SAT_MAX = {1'b0, {(REG_SIZE-1){1'b1}}};
  localparam logic [REG_SIZE-1:0] SAT_MIN = {1'b1, {(REG_SIZE-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [SHW-1:0]                     r_cnt;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  r_mulA;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  r_mulB;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  r_mulAcc;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  r_vectOut;
  logic                               r_ovf;
  logic [2:0]                         r_pc;
  logic                               r_pcOut;
  logic [1:0]                         r_flags;

  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  w_sum;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  w_diff;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  w_aluRes;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  w_mulStep;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  w_doneRes;
  logic                               w_accept;
  logic                               w_enterDone;
  logic                               w_startMul;
  logic                               w_mulRun;
  logic                               w_doneOvf;
  logic [2:0]                         w_donePc;
  logic                               w_branch;
  logic                               w_newN;
  logic                               w_newZ;

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign vectOut   = r_vectOut;
  assign pcWrEnOut = r_pcOut;
  assign flags     = r_flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // DONE behaves like IDLE when the result is being consumed, giving back-to-back accepts
  always_comb begin
    w_stateNext = r_state;
    w_enterDone = 1'b0;
    w_startMul  = 1'b0;
    w_mulRun    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          if (ExecuteOp == OP_MUL) begin
            w_stateNext = MUL;
            w_startMul  = 1'b1;
          end else begin
            w_stateNext = DONE;
            w_enterDone = 1'b1;
          end
        end else if ((r_state == DONE) && out_ready) begin
          w_stateNext = IDLE;
        end
      end
      MUL: begin
        w_mulRun = 1'b1;
        if (r_cnt == '0) begin
          w_stateNext = DONE;
          w_enterDone = 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < VEC_SIZE; i++) begin
      w_sum[i]  = vect1[i] + vect2[i];
      w_diff[i] = vect1[i] - vect2[i];
`ifdef VEXEC_SATURATE_EN
      if ((vect1[i][MSB] == vect2[i][MSB]) && (w_sum[i][MSB] != vect1[i][MSB]))
        w_sum[i] = vect1[i][MSB] ? SAT_MIN : SAT_MAX;
      if ((vect1[i][MSB] != vect2[i][MSB]) && (w_diff[i][MSB] != vect1[i][MSB]))
        w_diff[i] = vect1[i][MSB] ? SAT_MIN : SAT_MAX;
`endif
      case (ExecuteOp)
        OP_ADD:  w_aluRes[i] = w_sum[i];
        OP_SUB:  w_aluRes[i] = w_diff[i];
        OP_AND:  w_aluRes[i] = vect1[i] & vect2[i];
        OP_OR:   w_aluRes[i] = vect1[i] | vect2[i];
        OP_XOR:  w_aluRes[i] = vect1[i] ^ vect2[i];
        OP_SLL:  w_aluRes[i] = vect1[i] << vect2[i][SHW-1:0];
        OP_MOV:  w_aluRes[i] = vect2[i];
        default: w_aluRes[i] = '0;
      endcase
    end
  end

  // One multiplier bit per cycle: the multiplicand shifts left while the multiplier shifts right
  always_comb begin
    for (int i = 0; i < VEC_SIZE; i++)
      w_mulStep[i] = r_mulAcc[i] + ({REG_SIZE{r_mulB[i][0]}} & r_mulA[i]);
  end

  assign w_doneRes = (r_state == MUL) ? w_mulStep : w_aluRes;
  assign w_doneOvf = (r_state == MUL) ? r_ovf : overwriteFlags;
  assign w_donePc  = (r_state == MUL) ? r_pc : pcWrEn;

  always_comb begin
    w_newN = 1'b0;
    w_newZ = 1'b1;
    for (int i = 0; i < VEC_SIZE; i++) begin
      w_newN = w_newN | w_doneRes[i][MSB];
      w_newZ = w_newZ & (w_doneRes[i] == '0);
    end
  end

  // Branch uses the flags as they stood before this op's own update
  always_comb begin
    case (w_donePc)
      3'b100:  w_branch = ~r_flags[1];
      3'b010:  w_branch = r_flags[1];
      3'b001:  w_branch = r_flags[0];
      3'b011:  w_branch = ~r_flags[0];
      default: w_branch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_mulA    <= '0;
      r_mulB    <= '0;
      r_mulAcc  <= '0;
      r_ovf     <= 1'b0;
      r_pc      <= 3'b000;
      r_vectOut <= '0;
      r_pcOut   <= 1'b0;
      r_flags   <= 2'b00;
    end else begin
      if (w_startMul) begin
        r_mulA   <= vect1;
        r_mulB   <= vect2;
        r_mulAcc <= '0;
        r_cnt    <= CNT_INIT;
        r_ovf    <= overwriteFlags;
        r_pc     <= pcWrEn;
      end else if (w_mulRun) begin
        for (int i = 0; i < VEC_SIZE; i++) begin
          r_mulAcc[i] <= w_mulStep[i];
          r_mulA[i]   <= r_mulA[i] << 1;
          r_mulB[i]   <= r_mulB[i] >> 1;
        end
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if (w_enterDone) begin
        r_vectOut <= w_doneRes;
        r_pcOut   <= w_branch;
        if (w_doneOvf) r_flags <= {w_newZ, w_newN};
      end
    end
  end

endmodule

// File: tb/tb_vector_execute_unit.sv
// Self-checking bench for vector_execute_unit (REG_SIZE=16, VEC_SIZE=4) against an arithmetic reference model.
`timescale 1ns/1ps
module tb_vector_execute_unit;

  localparam int RS = 16;
  localparam int VS = 4;
  typedef logic [VS-1:0][RS-1:0] vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] ExecuteOp = 3'd0;
  logic       overwriteFlags = 1'b0;
  logic [2:0] pcWrEn = 3'd0;
  vec_t       vect1 = '0;
  vec_t       vect2 = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  vec_t       vectOut;
  logic       pcWrEnOut;
  logic [1:0] flags;

  int   passCount = 0;
  int   checkCount = 0;
  logic refZ = 1'b0;
  logic refN = 1'b0;

  always #5 clk = ~clk;

  vector_execute_unit #(.REG_SIZE(RS), .VEC_SIZE(VS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ExecuteOp(ExecuteOp), .overwriteFlags(overwriteFlags), .pcWrEn(pcWrEn),
    .vect1(vect1), .vect2(vect2), .out_valid(out_valid), .out_ready(out_ready),
    .vectOut(vectOut), .pcWrEnOut(pcWrEnOut), .flags(flags)
  );

  // Reference lane result computed with wide integer arithmetic, truncated to the lane width
  function automatic logic [RS-1:0] refLane(input logic [2:0] op, input logic [RS-1:0] a, input logic [RS-1:0] b);
    longint ua, ub, r;
    int sa, sb;
    logic [3:0] sh;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); sh = b[3:0];
    r = 0;
    case (op)
`ifdef VEXEC_SATURATE_EN
      3'd0: begin r = longint'(sa) + sb; if (r > 32767) r = 32767; if (r < -32768) r = -32768; end
      3'd1: begin r = longint'(sa) - sb; if (r > 32767) r = 32767; if (r < -32768) r = -32768; end
`else
      3'd0: r = ua + ub;
      3'd1: r = ua - ub;
`endif
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = ua << sh;
      3'd6: r = ua * ub;
      default: r = ub;
    endcase
    return r[RS-1:0];
  endfunction

  task automatic refOp(input logic [2:0] op, input logic ovf, input logic [2:0] pc,
                       input vec_t a, input vec_t b, output vec_t e, output logic ep);
    logic anyNeg, allZero;
    anyNeg = 1'b0; allZero = 1'b1;
    for (int i = 0; i < VS; i++) begin
      e[i] = refLane(op, a[i], b[i]);
      if (e[i] >= 16'h8000) anyNeg = 1'b1;
      if (e[i] != 0) allZero = 1'b0;
    end
    case (pc)
      3'b100:  ep = !refZ;
      3'b010:  ep = refZ;
      3'b001:  ep = refN;
      3'b011:  ep = !refN;
      default: ep = 1'b0;
    endcase
    if (ovf) begin refN = anyNeg; refZ = allZero; end
  endtask

  // Present an op at a falling edge and hold it until accepted; returns in the cycle after accept
  task automatic issue(input logic [2:0] op, input logic ovf, input logic [2:0] pc, input vec_t a, input vec_t b);
    int n;
    n = 0;
    ExecuteOp = op; overwriteFlags = ovf; pcWrEn = pc; vect1 = a; vect2 = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checkCount++;
      $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checkCount++;
      $display("[TB] FAIL done_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1; in_valid = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_held_valid: got %b required 0", out_valid);
    else passCount++;
    reset = 1'b1;
    @(negedge clk);
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid);
    else passCount++;
    checkCount++;
    if (vectOut !== '0) $display("[TB] FAIL reset_vectOut: got %h required 0", vectOut);
    else passCount++;
    checkCount++;
    if (flags !== 2'b00) $display("[TB] FAIL reset_flags: got %b required 00", flags);
    else passCount++;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
    else passCount++;
    checkCount++;
    if (pcWrEnOut !== 1'b0) $display("[TB] FAIL reset_pcWrEnOut: got %b required 0", pcWrEnOut);
    else passCount++;
    refZ = 1'b0; refN = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t e;
    logic ep;
    out_ready = 1'b1;
    ExecuteOp = 3'd0; overwriteFlags = 1'b0; pcWrEn = 3'd0;
    vect1 = {16'd4, 16'd3, 16'd2, 16'd1}; vect2 = {4{16'd1}}; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    refOp(3'd0, 1'b0, 3'd0, {16'd4, 16'd3, 16'd2, 16'd1}, {4{16'd1}}, e, ep);
    checkCount++;
    if (vectOut !== e) $display("[TB] FAIL b2b_add: got %h required %h", vectOut, e);
    else passCount++;
    checkCount++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) $display("[TB] FAIL b2b_handshake: got valid=%b ready=%b required 1/1", out_valid, in_ready);
    else passCount++;
    ExecuteOp = 3'd1; overwriteFlags = 1'b1;
    vect1 = {4{16'd5}}; vect2 = {4{16'd5}};
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    refOp(3'd1, 1'b1, 3'd0, {4{16'd5}}, {4{16'd5}}, e, ep);
    checkCount++;
    if (vectOut !== e) $display("[TB] FAIL b2b_sub: got %h required %h", vectOut, e);
    else passCount++;
    checkCount++;
    if (flags !== 2'b10) $display("[TB] FAIL b2b_flags: got %b required 10", flags);
    else passCount++;
  endtask

  task automatic test_mul();
    vec_t a, b, e;
    logic ep;
    int busy, readyBad;
    a = {16'd7, 16'd256, 16'hFFFF, 16'd3};
    b = {16'd0, 16'd256, 16'd2, 16'd5};
    busy = 0; readyBad = 0;
    issue(3'd6, 1'b1, 3'd0, a, b);
    refOp(3'd6, 1'b1, 3'd0, a, b, e, ep);
    while (!out_valid && busy < 40) begin
      if (in_ready) readyBad++;
      busy++;
      @(negedge clk);
    end
    checkCount++;
    if (busy != 16) $display("[TB] FAIL mul_busy_cycles: got %0d required 16", busy);
    else passCount++;
    checkCount++;
    if (readyBad != 0) $display("[TB] FAIL mul_in_ready: got %0d ready cycles required 0", readyBad);
    else passCount++;
    checkCount++;
    if (vectOut !== e) $display("[TB] FAIL mul_result: got %h required %h", vectOut, e);
    else passCount++;
    checkCount++;
    if (flags !== {refZ, refN}) $display("[TB] FAIL mul_flags: got %b required %b", flags, {refZ, refN});
    else passCount++;
  endtask

  task automatic test_backpressure();
    vec_t a, b, a2, b2, e, e2;
    logic ep, ep2;
    int unstable, readyBad, validBad;
    unstable = 0; readyBad = 0; validBad = 0;
    for (int i = 0; i < VS; i++) begin
      a[i] = 16'($urandom); b[i] = 16'($urandom);
      a2[i] = 16'($urandom); b2[i] = 16'($urandom);
    end
    @(negedge clk);
    out_ready = 1'b0;
    issue(3'd4, 1'b0, 3'd0, a, b);
    refOp(3'd4, 1'b0, 3'd0, a, b, e, ep);
    ExecuteOp = 3'd0; overwriteFlags = 1'b0; pcWrEn = 3'd0; vect1 = a2; vect2 = b2; in_valid = 1'b1;
    repeat (4) begin
      if (vectOut !== e) unstable++;
      if (in_ready !== 1'b0) readyBad++;
      if (out_valid !== 1'b1) validBad++;
      @(negedge clk);
    end
    checkCount++;
    if (unstable != 0) $display("[TB] FAIL bp_stable: got %0d changed cycles required 0", unstable);
    else passCount++;
    checkCount++;
    if (readyBad != 0) $display("[TB] FAIL bp_in_ready: got %0d ready cycles required 0", readyBad);
    else passCount++;
    checkCount++;
    if (validBad != 0) $display("[TB] FAIL bp_out_valid: got %0d dropped cycles required 0", validBad);
    else passCount++;
    out_ready = 1'b1;
    #1;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b required 1", in_ready);
    else passCount++;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    refOp(3'd0, 1'b0, 3'd0, a2, b2, e2, ep2);
    checkCount++;
    if (vectOut !== e2) $display("[TB] FAIL bp_next_op: got %h required %h", vectOut, e2);
    else passCount++;
  endtask

  task automatic test_branch();
    vec_t e, z;
    logic ep;
    z = {4{16'd7}};
    issue(3'd1, 1'b1, 3'd0, z, z);
    refOp(3'd1, 1'b1, 3'd0, z, z, e, ep);
    checkCount++;
    if (flags !== 2'b10) $display("[TB] FAIL br_setz: got %b required 10", flags);
    else passCount++;
    issue(3'd7, 1'b0, 3'b010, z, z);
    refOp(3'd7, 1'b0, 3'b010, z, z, e, ep);
    checkCount++;
    if (pcWrEnOut !== 1'b1) $display("[TB] FAIL br_eq_taken: got %b required 1", pcWrEnOut);
    else passCount++;
    issue(3'd7, 1'b0, 3'b100, z, z);
    refOp(3'd7, 1'b0, 3'b100, z, z, e, ep);
    checkCount++;
    if (pcWrEnOut !== 1'b0) $display("[TB] FAIL br_ne_not_taken: got %b required 0", pcWrEnOut);
    else passCount++;
    issue(3'd7, 1'b0, 3'b110, z, z);
    refOp(3'd7, 1'b0, 3'b110, z, z, e, ep);
    checkCount++;
    if (pcWrEnOut !== 1'b0) $display("[TB] FAIL br_other_code: got %b required 0", pcWrEnOut);
    else passCount++;
    checkCount++;
    if (vectOut !== e) $display("[TB] FAIL br_mov_value: got %h required %h", vectOut, e);
    else passCount++;
  endtask

  task automatic test_saturation();
    vec_t e;
    logic ep;
    issue(3'd0, 1'b1, 3'd0, {4{16'h7FFF}}, {4{16'd1}});
    refOp(3'd0, 1'b1, 3'd0, {4{16'h7FFF}}, {4{16'd1}}, e, ep);
    checkCount++;
    if (vectOut !== e) $display("[TB] FAIL sat_add: got %h required %h", vectOut, e);
    else passCount++;
    checkCount++;
    if (flags !== {refZ, refN}) $display("[TB] FAIL sat_add_flags: got %b required %b", flags, {refZ, refN});
    else passCount++;
    issue(3'd1, 1'b1, 3'd0, {4{16'h8000}}, {4{16'd1}});
    refOp(3'd1, 1'b1, 3'd0, {4{16'h8000}}, {4{16'd1}}, e, ep);
    checkCount++;
    if (vectOut !== e) $display("[TB] FAIL sat_sub: got %h required %h", vectOut, e);
    else passCount++;
    checkCount++;
    if (flags !== {refZ, refN}) $display("[TB] FAIL sat_sub_flags: got %b required %b", flags, {refZ, refN});
    else passCount++;
  endtask

  task automatic test_random();
    vec_t a, b, e;
    logic ep;
    logic [2:0] op, pc;
    logic ovf;
    for (int t = 0; t < 40; t++) begin
      op = 3'($urandom_range(0, 7));
      pc = 3'($urandom_range(0, 7));
      ovf = 1'($urandom_range(0, 1));
      for (int i = 0; i < VS; i++) begin
        a[i] = 16'($urandom);
        b[i] = ($urandom_range(0, 4) == 0) ? a[i] : 16'($urandom);
      end
      issue(op, ovf, pc, a, b);
      refOp(op, ovf, pc, a, b, e, ep);
      waitDone();
      checkCount++;
      if (vectOut !== e) $display("[TB] FAIL rand_vec op=%0d: got %h required %h", op, vectOut, e);
      else passCount++;
      checkCount++;
      if (pcWrEnOut !== ep) $display("[TB] FAIL rand_pc op=%0d pc=%b: got %b required %b", op, pc, pcWrEnOut, ep);
      else passCount++;
      checkCount++;
      if (flags !== {refZ, refN}) $display("[TB] FAIL rand_flags op=%0d: got %b required %b", op, flags, {refZ, refN});
      else passCount++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_branch();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
